// File: rtl/branch_target_buffer_assoc.sv
// branch_target_buffer_assoc: fully associative BTB with valid bits, saturating direction counters and true-LRU replacement.
// Lookup is combinational and side-effect free; updates, invalidate and reset take effect at the rising edge.
module branch_target_buffer_assoc #(
  parameter int ENTRIES = 4,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] lookupPC,
  output logic [PC_W-1:0] lookupTarget,
  output logic            lookupHit,
  output logic            lookupTaken,
  input  logic            updValid,
  input  logic [PC_W-1:0] updPC,
  input  logic [PC_W-1:0] updTarget,
  input  logic            updTaken,
  input  logic            invalidate
);
  localparam int AW = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_ONE << (CNT_W - 1);
  localparam logic [AW-1:0]    AGE_LRU  = AW'(ENTRIES - 1);
  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [PC_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]   tag_d    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [PC_W-1:0]   target_d [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];
  logic [CNT_W-1:0]  cnt_d    [ENTRIES];
  logic [AW-1:0]     age_q    [ENTRIES];
  logic [AW-1:0]     age_d    [ENTRIES];
  logic              upd_hit;
  logic [AW-1:0]     upd_idx;
  logic              inv_any;
  logic [AW-1:0]     inv_idx;
  logic [AW-1:0]     lru_idx;
  logic [AW-1:0]     promo_idx;
  logic              do_upd;
  logic              lk_msb;
  always_comb begin
    lookupHit    = 1'b0;
    lookupTarget = '0;
    lk_msb       = 1'b0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == lookupPC) begin
        lookupHit    = 1'b1;
        lookupTarget = target_q[i];
        lk_msb       = cnt_q[i][CNT_W-1];
      end
    end
    lookupTaken = lookupHit & lk_msb;
  end
  // Downward scans so the lowest matching / invalid index wins.
  always_comb begin
    upd_hit = 1'b0;
    upd_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    lru_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == updPC) begin
        upd_hit = 1'b1;
        upd_idx = AW'(i);
      end
      if (!valid_q[i]) begin
        inv_any = 1'b1;
        inv_idx = AW'(i);
      end
      if (age_q[i] == AGE_LRU) lru_idx = AW'(i);
    end
    promo_idx = upd_hit ? upd_idx : (inv_any ? inv_idx : lru_idx);
    do_upd    = updValid && !invalidate && (upd_hit || updTaken);
  end
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i]  = valid_q[i];
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      cnt_d[i]    = cnt_q[i];
      age_d[i]    = age_q[i];
    end
    if (do_upd) begin
      for (int i = 0; i < ENTRIES; i++)
        if (age_q[i] < age_q[promo_idx]) age_d[i] = age_q[i] + AW'(1);
      age_d[promo_idx]    = '0;
      target_d[promo_idx] = updTarget;
      if (upd_hit)
        cnt_d[promo_idx] = updTaken ? (cnt_q[promo_idx] == CNT_MAX ? CNT_MAX : cnt_q[promo_idx] + CNT_ONE)
                                    : (cnt_q[promo_idx] == '0 ? '0 : cnt_q[promo_idx] - CNT_ONE);
      else begin
        valid_d[promo_idx] = 1'b1;
        tag_d[promo_idx]   = updPC;
        cnt_d[promo_idx]   = CNT_INIT;
      end
    end
    if (invalidate)
      for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (!reset) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
        age_q[i]    <= AW'(i);
      end else begin
        valid_q[i]  <= valid_d[i];
        tag_q[i]    <= tag_d[i];
        target_q[i] <= target_d[i];
        cnt_q[i]    <= cnt_d[i];
        age_q[i]    <= age_d[i];
      end
    end
  end
endmodule

// File: tb/tb_branch_target_buffer_assoc.sv
// tb_branch_target_buffer_assoc: directed checks of lookup, allocation, LRU eviction,
// counter saturation, invalidate and reset for the default 4-entry configuration.
module tb_branch_target_buffer_assoc;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] lookupPC = '0;
  logic [31:0] lookupTarget;
  logic        lookupHit;
  logic        lookupTaken;
  logic        updValid = 1'b0;
  logic [31:0] updPC = '0;
  logic [31:0] updTarget = '0;
  logic        updTaken = 1'b0;
  logic        invalidate = 1'b0;
  int checks = 0;
  int failures = 0;
  branch_target_buffer_assoc #(.ENTRIES(4), .PC_W(32), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .lookupPC(lookupPC), .lookupTarget(lookupTarget),
    .lookupHit(lookupHit), .lookupTaken(lookupTaken), .updValid(updValid),
    .updPC(updPC), .updTarget(updTarget), .updTaken(updTaken), .invalidate(invalidate)
  );
  always #5 clk = ~clk;
  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    @(negedge clk);
    updValid = 1'b1;
    updPC = pc;
    updTarget = tgt;
    updTaken = tk;
    @(negedge clk);
    updValid = 1'b0;
  endtask
  task automatic look(input string name, input logic [31:0] pc, input logic eh,
                      input logic [31:0] et, input logic ek);
    lookupPC = pc;
    #1;
    checks++;
    if (lookupHit !== eh) begin
      failures++;
      $display("FAIL %s hit pc=%h got=%b exp=%b", name, pc, lookupHit, eh);
    end
    checks++;
    if (lookupTarget !== et) begin
      failures++;
      $display("FAIL %s target pc=%h got=%h exp=%h", name, pc, lookupTarget, et);
    end
    checks++;
    if (lookupTaken !== ek) begin
      failures++;
      $display("FAIL %s taken pc=%h got=%b exp=%b", name, pc, lookupTaken, ek);
    end
  endtask
  task automatic test_reset();
    apply_reset();
    look("reset_zero", 32'h0, 1'b0, 32'h0, 1'b0);
    look("reset_other", 32'h100, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic test_alloc_and_update();
    upd(32'h100, 32'h200, 1'b1);
    look("alloc", 32'h100, 1'b1, 32'h200, 1'b1);
    upd(32'h100, 32'h200, 1'b0);
    look("dec_to_1", 32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h100, 32'h240, 1'b1);
    look("retarget", 32'h100, 1'b1, 32'h240, 1'b1);
    look("neighbour_miss", 32'h101, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic test_no_alloc();
    upd(32'h104, 32'h300, 1'b0);
    look("nt_no_alloc", 32'h104, 1'b0, 32'h0, 1'b0);
  endtask
  task automatic test_back_to_back();
    @(negedge clk);
    lookupPC = 32'h300;
    updValid = 1'b1;
    updPC = 32'h300;
    updTarget = 32'h380;
    updTaken = 1'b1;
    #1;
    checks++;
    if (lookupHit !== 1'b0) begin
      failures++;
      $display("FAIL same_cycle_bypass hit got=%b exp=0", lookupHit);
    end
    @(negedge clk);
    updValid = 1'b0;
    look("after_same_cycle", 32'h300, 1'b1, 32'h380, 1'b1);
  endtask
  task automatic test_lru();
    apply_reset();
    upd(32'h10, 32'h1010, 1'b1);
    upd(32'h20, 32'h1020, 1'b1);
    upd(32'h30, 32'h1030, 1'b1);
    upd(32'h40, 32'h1040, 1'b1);
    upd(32'h10, 32'h1010, 1'b1);
    upd(32'h50, 32'h1050, 1'b1);
    look("lru_evict_20", 32'h20, 1'b0, 32'h0, 1'b0);
    look("lru_keep_10", 32'h10, 1'b1, 32'h1010, 1'b1);
    look("lru_keep_30", 32'h30, 1'b1, 32'h1030, 1'b1);
    look("lru_keep_40", 32'h40, 1'b1, 32'h1040, 1'b1);
    look("lru_new_50", 32'h50, 1'b1, 32'h1050, 1'b1);
    upd(32'h60, 32'h1060, 1'b1);
    look("lru_evict_30", 32'h30, 1'b0, 32'h0, 1'b0);
    look("lru_keep_40b", 32'h40, 1'b1, 32'h1040, 1'b1);
    look("lru_new_60", 32'h60, 1'b1, 32'h1060, 1'b1);
  endtask
  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 4; i++) upd(32'h70, 32'h700, 1'b1);
    look("sat_hi", 32'h70, 1'b1, 32'h700, 1'b1);
    upd(32'h70, 32'h700, 1'b0);
    look("sat_nt1", 32'h70, 1'b1, 32'h700, 1'b1);
    upd(32'h70, 32'h700, 1'b0);
    look("sat_nt2", 32'h70, 1'b1, 32'h700, 1'b0);
    upd(32'h70, 32'h700, 1'b0);
    upd(32'h70, 32'h700, 1'b0);
    look("sat_lo", 32'h70, 1'b1, 32'h700, 1'b0);
    upd(32'h70, 32'h700, 1'b1);
    look("sat_lo_plus1", 32'h70, 1'b1, 32'h700, 1'b0);
    upd(32'h70, 32'h700, 1'b1);
    look("sat_lo_plus2", 32'h70, 1'b1, 32'h700, 1'b1);
  endtask
  task automatic test_invalidate();
    @(negedge clk);
    invalidate = 1'b1;
    updValid = 1'b1;
    updPC = 32'h60;
    updTarget = 32'h600;
    updTaken = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    updValid = 1'b0;
    look("inv_clear_70", 32'h70, 1'b0, 32'h0, 1'b0);
    look("inv_drop_60", 32'h60, 1'b0, 32'h0, 1'b0);
    upd(32'h60, 32'h600, 1'b1);
    look("inv_realloc_60", 32'h60, 1'b1, 32'h600, 1'b1);
  endtask
  task automatic test_mid_reset();
    upd(32'h80, 32'h800, 1'b1);
    look("pre_reset_80", 32'h80, 1'b1, 32'h800, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    updValid = 1'b1;
    updPC = 32'h90;
    updTarget = 32'h900;
    updTaken = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    updValid = 1'b0;
    look("mid_reset_80", 32'h80, 1'b0, 32'h0, 1'b0);
    look("mid_reset_90", 32'h90, 1'b0, 32'h0, 1'b0);
    look("mid_reset_zero", 32'h0, 1'b0, 32'h0, 1'b0);
  endtask
  initial begin
    test_reset();
    test_alloc_and_update();
    test_no_alloc();
    test_back_to_back();
    test_lru();
    test_saturation();
    test_invalidate();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_target_buffer_assoc.md
Name: branch_target_buffer_assoc

Overview:
- Parametrised, fully associative branch target buffer with per-entry valid bit, 2-bit-style saturating direction counter and true-LRU replacement.
- Sits in the fetch stage. The lookup port is driven by the fetch PC and returns target, hit and taken prediction combinationally.
- The update port is driven by branch resolution in execute.
- Successor to the fixed 3-entry shift-style BTB; adds depth/width parameters, valid bits, direction prediction, not-taken filtering and an explicit invalidate.

Parameters:
- ENTRIES, 4, number of entries; power of two, 2..16.
- PC_W, 32, width of PC and target fields.
- CNT_W, 2, direction counter width; 1..3.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  synchronous, active-low reset.
- lookupPC  input  PC_W  fetch PC to look up.
- lookupTarget  output  PC_W  stored target of hitting entry; 0 on miss.
- lookupHit  output  1  a valid entry's tag equals lookupPC.
- lookupTaken  output  1  lookupHit AND MSB of hitting entry's counter.
- updValid  input  1  resolved branch present this cycle.
- updPC  input  PC_W  PC of resolved branch.
- updTarget  input  PC_W  resolved target.
- updTaken  input  1  resolved direction.
- invalidate  input  1  clear all valid bits (pipeline flush or self-modifying code).

Behaviour:
- State per entry i: valid[i], tag[i] (PC_W), target[i] (PC_W), cnt[i] (CNT_W), age[i] (clog2(ENTRIES)).
- Age encoding: age 0 = MRU, ENTRIES-1 = LRU. Ages always form a permutation of 0..ENTRIES-1.
- Reset (reset==0 at posedge):
  - valid=0, tag=0, target=0, cnt=0, age[i]=i.
  - Outputs are combinational from state, so after reset lookupHit=0, lookupTaken=0, lookupTarget=0.
- Lookup is purely combinational, zero latency.
  - Match requires valid AND tag==lookupPC. Unique tags are guaranteed by the update rules.
  - A defensive lowest-index priority mux is still required.
  - Lookup has no side effects; it does not change LRU.
- Update (posedge, reset==1, invalidate==0, updValid==1); updMatch uses the same valid/tag compare against updPC:
  - Hit, entry h:
    - target[h] <= updTarget.
    - cnt[h] saturating +1 if updTaken, else saturating -1. Bounds 0 and 2^CNT_W-1.
    - Promote h to MRU.
  - Miss, updTaken=1:
    - Victim = lowest-index invalid entry if any, else the entry with age ENTRIES-1.
    - Victim gets valid=1, tag=updPC, target=updTarget, cnt=2^(CNT_W-1) (weakly taken).
    - Promote victim to MRU.
  - Miss, updTaken=0: no state change. Not-taken branches are never allocated.
- Promote-to-MRU of entry p:
  - Every entry with age < age[p] increments by 1.
  - age[p] <= 0.
  - Others unchanged.
- invalidate=1 at posedge (reset==1):
  - All valid <= 0. tag/target/cnt/age unchanged.
  - Overrides a same-cycle update; that update is dropped.
- Reset overrides invalidate and update.
- Same-cycle lookup and update of the same PC: lookup returns pre-update state. No write-through bypass.
- updValid=0: no state change.
- All arithmetic is unsigned. PCs are compared at full PC_W width, with no alignment bits dropped.

Test Plan:
- Reset with ENTRIES=4, then lookupPC=0x0 -> lookupHit=0, lookupTarget=0 (all-zero tag must not hit while invalid).
- Update PC 0x100→0x200 taken, next cycle lookup 0x100 -> hit=1, target=0x200, taken=1 (cnt=2). Then one not-taken update -> cnt=1, taken=0, hit=1, target stays 0x200 only if updTarget=0x200.
- Update 0x104 not taken (miss) -> no allocation; lookup 0x104 -> hit=0.
- Fill with 0x10,0x20,0x30,0x40 taken; update 0x10 taken again (hit → MRU); insert 0x50 taken -> 0x20 evicted (hit=0), 0x10/0x30/0x40/0x50 hit.
- Saturation: four taken updates to one PC -> cnt=3; three not-taken -> cnt=0, taken=0; a further not-taken keeps cnt=0.
- invalidate asserted with a same-cycle updValid for 0x60 -> all lookups miss, 0x60 not allocated. Also drive reset low mid-sequence -> all state returns to reset values next cycle.
